// File: rtl/speck_serial_add.sv
// Bit-serial SPECK modular adder: sum = ROR(x, ALPHA) + y, one bit per clock,
// LSB first, through a single AOIG full-adder cell.

module speck_aoig_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic cout_n;

  // Carry built as an and-or-invert of the majority terms, then restored.
  assign cout_n = ~((a & b) | (cin & (a | b)));
  assign cout   = ~cout_n;
  assign sum    = a ^ b ^ cin;
endmodule

module speck_serial_add #(
  parameter int WIDTH = 16,
  parameter int ALPHA = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum;
  logic             fa_cout;

  function automatic logic [WIDTH-1:0] ror_alpha(input logic [WIDTH-1:0] v);
    return (v >> ALPHA) | (v << (WIDTH - ALPHA));
  endfunction

  speck_aoig_fa u_fa (
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry_q),
    .sum (fa_sum),
    .cout(fa_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      res_q     <= '0;
      carry_q   <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr     <= ror_alpha(x_in);
            b_sr     <= y_in;
            carry_q  <= 1'b0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          // Sum bits enter at the MSB so bit 0 lands at res_q[0] after WIDTH shifts.
          res_q   <= {fa_sum, res_q[WIDTH-1:1]};
          carry_q <= fa_cout;
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          if (cnt == LAST_BIT) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign sum_out   = out_valid ? res_q : '0;
  assign carry_out = out_valid & carry_q;
endmodule

// File: tb/tb_speck_serial_add.sv
// Scoreboard bench for speck_serial_add: directed vectors plus a short
// back-to-back run checked against a rotate-and-add reference.

module tb_speck_serial_add;
  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] x_in = '0;
  logic [15:0] y_in = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] sum_out;
  logic        carry_out;

  speck_serial_add #(.WIDTH(16), .ALPHA(7)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_in     (x_in),
    .y_in     (y_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum_out  (sum_out),
    .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] s;
    logic        c;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          acc_n = 0;
  int          last_acc = 0;
  logic [15:0] exp_s = '0;
  logic        exp_c = 1'b0;
  logic        prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=no_event", name);
  endtask

  function automatic logic [16:0] model(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] r;
    r = {x[6:0], x[15:7]};
    return {1'b0, r} + {1'b0, y};
  endfunction

  // Monitor: pops on every output transfer, pushes on every input accept.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      prev_ov = 1'b0;
    end else begin
      if (!out_valid) begin
        chk("idle_sum_zero", 32'(sum_out), 32'h0);
        chk("idle_carry_zero", 32'(carry_out), 32'h0);
      end
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) fail("unexpected_out_valid");
        else chk("latency", cyc, sb[0].acc + W);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) fail("unexpected_transfer");
        else begin
          e = sb.pop_front();
          chk("sum", 32'(sum_out), 32'(e.s));
          chk("carry", 32'(carry_out), 32'(e.c));
        end
      end
      prev_ov = out_valid;
      if (in_valid && in_ready) begin
        sb.push_back('{exp_s, exp_c, cyc + 1});
        last_acc = cyc + 1;
        acc_n++;
      end
    end
  end

  task automatic send(input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] s, input logic c);
    int n0;
    n0 = acc_n;
    x_in = x;
    y_in = y;
    exp_s = s;
    exp_c = c;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && acc_n == n0; i++) begin
      @(negedge clk);
      #1;
    end
    if (acc_n == n0) fail("accept_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) fail("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] m;
    logic [15:0] rx;
    logic [15:0] ry;
    int          prev_acc;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_sum", 32'(sum_out), 32'h0);
    chk("rst_carry", 32'(carry_out), 32'h0);
    @(posedge clk);
    #1;

    send(16'h0000, 16'h0000, 16'h0000, 1'b0);
    in_valid = 1'b0;
    wait_drain();

    send(16'h0080, 16'hFFFF, 16'h0000, 1'b1);
    in_valid = 1'b0;
    wait_drain();

    // Backpressure in DONE with a new pair already offered.
    out_ready = 1'b0;
    send(16'h6574, 16'h694C, 16'h5216, 1'b1);
    in_valid = 1'b0;
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    if (!out_valid) fail("done_timeout");
    x_in = 16'h0080;
    y_in = 16'hFFFF;
    exp_s = 16'h0000;
    exp_c = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_out_valid", 32'(out_valid), 32'h1);
      chk("hold_sum", 32'(sum_out), 32'h5216);
      chk("hold_carry", 32'(carry_out), 32'h1);
      chk("hold_in_ready", 32'(in_ready), 32'h0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("done_no_accept", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'h1);
    chk("idle_out_valid", 32'(out_valid), 32'h0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_drain();

    // Reset during the fifth RUN cycle discards the operation.
    m = model(16'h1234, 16'h1111);
    send(16'h1234, 16'h1111, m[15:0], m[16]);
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    chk("midrun_rst_in_ready", 32'(in_ready), 32'h1);
    chk("midrun_rst_out_valid", 32'(out_valid), 32'h0);
    chk("midrun_rst_sum", 32'(sum_out), 32'h0);
    chk("midrun_rst_carry", 32'(carry_out), 32'h0);
    @(posedge clk);
    #1;
    send(16'h0080, 16'hFFFF, 16'h0000, 1'b1);
    in_valid = 1'b0;
    wait_drain();

    // Back-to-back with in_valid and out_ready held high.
    out_ready = 1'b1;
    prev_acc = 0;
    for (int i = 0; i < 3; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      m = model(rx, ry);
      send(rx, ry, m[15:0], m[16]);
      if (i > 0) chk("b2b_spacing", last_acc - prev_acc, W + 2);
      prev_acc = last_acc;
    end
    in_valid = 1'b0;
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
